// File: rtl/spi_packet_tx.sv
// Response-packet framer for the SPI link: emits [CMD][LEN][PAYLOAD...][CRC_H][CRC_L]
// one word per valid/ready handshake, with a CRC-16/CCITT-FALSE over CMD, LEN and payload bytes.
module spi_packet_tx #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MAX_PAYLOAD = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [7:0]            start_cmd,
    input  logic [7:0]            start_length,
    input  logic [DATA_WIDTH-1:0] payload_data,
    input  logic                  payload_valid,
    output logic                  payload_ready,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  len_err,
    output logic                  done,
    output logic                  busy
);

    localparam int unsigned CNT_W   = $clog2(MAX_PAYLOAD + 1);
    localparam int unsigned CMP_W   = (CNT_W > 8) ? CNT_W + 1 : 9;
    localparam int unsigned NBYTES  = DATA_WIDTH / 8;
    localparam logic [7:0]  MAX_LEN = 8'(MAX_PAYLOAD);
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        TX_CMD,
        TX_LEN,
        TX_PAYLOAD,
        TX_CRC_H,
        TX_CRC_L
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [7:0]        len_q, len_d;
    logic [15:0]       crc_q, crc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              len_err_q, len_err_d;
    logic              done_q, done_d;
    logic              last_word;

    // One byte of CRC-16/CCITT-FALSE, MSB first
    function automatic logic [15:0] crc_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
        end
        return c;
    endfunction

    // Whole payload word, most-significant byte first
    function automatic logic [15:0] crc_word(input logic [15:0] crc, input logic [DATA_WIDTH-1:0] w);
        logic [15:0] c;
        c = crc;
        for (int i = NBYTES - 1; i >= 0; i--) begin
            c = crc_byte(c, w[i*8 +: 8]);
        end
        return c;
    endfunction

    assign last_word = (CMP_W'(cnt_q) + CMP_W'(1)) == CMP_W'(len_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            len_q     <= '0;
            crc_q     <= CRC_INIT;
            cnt_q     <= '0;
            len_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            len_q     <= len_d;
            crc_q     <= crc_d;
            cnt_q     <= cnt_d;
            len_err_q <= len_err_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        len_d         = len_q;
        crc_d         = crc_q;
        cnt_d         = cnt_q;
        len_err_d     = 1'b0;
        done_d        = 1'b0;
        start_ready   = 1'b0;
        tx_valid      = 1'b0;
        tx_data       = '0;
        payload_ready = 1'b0;

        case (state_q)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    if (start_length > MAX_LEN) begin
                        len_err_d = 1'b1;
                    end else begin
                        cmd_d   = start_cmd;
                        len_d   = start_length;
                        crc_d   = CRC_INIT;
                        cnt_d   = '0;
                        state_d = TX_CMD;
                    end
                end
            end
            TX_CMD: begin
                tx_valid = 1'b1;
                tx_data  = DATA_WIDTH'(cmd_q);
                if (tx_ready) begin
                    crc_d   = crc_byte(crc_q, cmd_q);
                    state_d = TX_LEN;
                end
            end
            TX_LEN: begin
                tx_valid = 1'b1;
                tx_data  = DATA_WIDTH'(len_q);
                if (tx_ready) begin
                    crc_d   = crc_byte(crc_q, len_q);
                    state_d = (len_q == 8'd0) ? TX_CRC_H : TX_PAYLOAD;
                end
            end
            TX_PAYLOAD: begin
                // Zero-latency pass-through of the EKF word stream
                tx_valid      = payload_valid;
                tx_data       = payload_data;
                payload_ready = tx_ready;
                if (payload_valid && tx_ready) begin
                    crc_d = crc_word(crc_q, payload_data);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_word) begin
                        state_d = TX_CRC_H;
                    end
                end
            end
            TX_CRC_H: begin
                tx_valid = 1'b1;
                tx_data  = DATA_WIDTH'(crc_q[15:8]);
                if (tx_ready) begin
                    state_d = TX_CRC_L;
                end
            end
            TX_CRC_L: begin
                tx_valid = 1'b1;
                tx_data  = DATA_WIDTH'(crc_q[7:0]);
                if (tx_ready) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign len_err = len_err_q;
    assign done    = done_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_spi_packet_tx.sv
// Self-checking bench for spi_packet_tx: randomized packets and handshakes compared
// against a byte-stream CRC model and an expected word list built from the request.
module tb_spi_packet_tx;

    localparam int unsigned DW   = 32;
    localparam int unsigned MAXP = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_valid;
    logic          start_ready;
    logic [7:0]    start_cmd;
    logic [7:0]    start_length;
    logic [DW-1:0] payload_data;
    logic          payload_valid;
    logic          payload_ready;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          len_err;
    logic          done;
    logic          busy;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] pl_mem [MAXP];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] got_q [$];

    spi_packet_tx #(.DATA_WIDTH(DW), .MAX_PAYLOAD(MAXP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .start_cmd    (start_cmd),
        .start_length (start_length),
        .payload_data (payload_data),
        .payload_valid(payload_valid),
        .payload_ready(payload_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .len_err      (len_err),
        .done         (done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // CRC over the serialized packet bit stream (poly 0x1021, init 0xFFFF, MSB first)
    function automatic logic [15:0] model_crc(input logic [7:0] cmd, input logic [7:0] len);
        logic [7:0]  bytes [$];
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        bytes.push_back(cmd);
        bytes.push_back(len);
        for (int w = 0; w < int'(len); w++)
            for (int b = DW / 8 - 1; b >= 0; b--) bytes.push_back(pl_mem[w][b*8 +: 8]);
        foreach (bytes[i]) begin
            for (int k = 7; k >= 0; k--) begin
                fb = c[15] ^ bytes[i][k];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    task automatic build_expected(input logic [7:0] cmd, input logic [7:0] len);
        logic [15:0] c;
        c = model_crc(cmd, len);
        exp_q.delete();
        exp_q.push_back(DW'(cmd));
        exp_q.push_back(DW'(len));
        for (int w = 0; w < int'(len); w++) exp_q.push_back(pl_mem[w]);
        exp_q.push_back(DW'(c[15:8]));
        exp_q.push_back(DW'(c[7:0]));
    endtask

    // Drives one request and its payload; rdy_pct < 0 toggles tx_ready each cycle
    task automatic send_packet(input logic [7:0] cmd, input logic [7:0] len, input int rdy_pct,
                               input int pv_pct, output int cyc, output int busy_cyc,
                               output int stall_viol, output int consumed, output bit timed_out);
        int       pidx;
        bit       pl_taken, prev_stall, done_seen;
        logic [DW-1:0] prev_data;
        got_q.delete();
        pidx = 0; pl_taken = 0; prev_stall = 0; done_seen = 0; prev_data = '0;
        cyc = 0; busy_cyc = 0; stall_viol = 0;
        @(negedge clk);
        start_valid = 1'b1; start_cmd = cmd; start_length = len;
        payload_valid = 1'b0; tx_ready = 1'b0;
        while (!done_seen && cyc < 2000) begin
            @(negedge clk);
            start_valid = 1'b0;
            cyc++;
            if (pl_taken) begin pidx++; payload_valid = 1'b0; end
            if (rdy_pct < 0) tx_ready = (cyc % 2 == 1);
            else tx_ready = (int'($urandom_range(99)) < rdy_pct);
            if (!payload_valid && pidx < int'(len))
                payload_valid = (int'($urandom_range(99)) < pv_pct);
            payload_data = payload_valid ? pl_mem[pidx] : DW'($urandom);
            #1;
            if (busy === 1'b1) busy_cyc++;
            if (done === 1'b1) done_seen = 1;
            if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data)) stall_viol++;
            if (tx_valid === 1'b1 && tx_ready) got_q.push_back(tx_data);
            prev_stall = (tx_valid === 1'b1) && !tx_ready;
            prev_data  = tx_data;
            pl_taken   = payload_valid && (payload_ready === 1'b1);
        end
        if (pl_taken) pidx++;
        payload_valid = 1'b0;
        tx_ready      = 1'b0;
        consumed      = pidx;
        timed_out     = !done_seen;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL reset_start_ready: got %b exp 1", start_ready); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b exp 0", tx_valid); end
        checks++; if (tx_data !== '0) begin errors++; $display("FAIL reset_tx_data: got %h exp 0", tx_data); end
        checks++; if (payload_ready !== 1'b0) begin errors++; $display("FAIL reset_payload_ready: got %b exp 0", payload_ready); end
        checks++; if ({len_err, done, busy} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b exp 000", {len_err, done, busy}); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_zero_len();
        int cyc, bc, sv, cons; bit to;
        build_expected(8'h01, 8'd0);
        send_packet(8'h01, 8'd0, 100, 100, cyc, bc, sv, cons, to);
        checks++; if (to) begin errors++; $display("FAIL zero_timeout: no done seen"); end
        checks++; if (got_q.size() != 4) begin errors++; $display("FAIL zero_count: got %0d exp 4", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== 32'h01 || got_q[1] !== 32'h00) begin errors++; $display("FAIL zero_hdr: got %h %h exp 1 0", got_q[0], got_q[1]); end
            checks++; if (got_q[2] !== 32'h2E || got_q[3] !== 32'h3E) begin errors++; $display("FAIL zero_crc: got %h %h exp 2e 3e", got_q[2], got_q[3]); end
        end
        checks++; if (exp_q[2] !== 32'h2E || exp_q[3] !== 32'h3E) begin errors++; $display("FAIL zero_model: got %h %h exp 2e 3e", exp_q[2], exp_q[3]); end
        checks++; if (cyc != 5) begin errors++; $display("FAIL zero_latency: got %0d exp 5", cyc); end
        checks++; if (bc != 4) begin errors++; $display("FAIL zero_busy: got %0d exp 4", bc); end
        @(negedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_width: got %b exp 0", done); end
    endtask

    task automatic test_basic(input int rdy, input int pv, input string tag);
        int cyc, bc, sv, cons; bit to;
        pl_mem[0] = 32'h11223344; pl_mem[1] = 32'h55667788; pl_mem[2] = 32'h99AABBCC;
        build_expected(8'h10, 8'd3);
        send_packet(8'h10, 8'd3, rdy, pv, cyc, bc, sv, cons, to);
        checks++; if (to) begin errors++; $display("FAIL %s_timeout: no done seen", tag); end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL %s_count: got %0d exp %0d", tag, got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL %s_word%0d: got %h exp %h", tag, i, got_q[i], exp_q[i]); end
        end
        checks++; if (sv != 0) begin errors++; $display("FAIL %s_stall: got %0d violations exp 0", tag, sv); end
        checks++; if (cons != 3) begin errors++; $display("FAIL %s_consumed: got %0d exp 3", tag, cons); end
        if (rdy == 100 && pv == 100) begin
            checks++; if (cyc != 8) begin errors++; $display("FAIL %s_latency: got %0d exp 8", tag, cyc); end
        end
    endtask

    task automatic test_len_err();
        int cyc, bc, sv, cons; bit to;
        @(negedge clk);
        start_valid = 1'b1; start_cmd = 8'h77; start_length = 8'd17;
        @(negedge clk);
        start_valid = 1'b0; #1;
        checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL lenerr_pulse: got %b exp 1", len_err); end
        checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL lenerr_idle: got v=%b busy=%b exp 0 0", tx_valid, busy); end
        @(negedge clk); #1;
        checks++; if (len_err !== 1'b0 || tx_valid !== 1'b0) begin errors++; $display("FAIL lenerr_clear: got e=%b v=%b exp 0 0", len_err, tx_valid); end
        for (int i = 0; i < int'(MAXP); i++) pl_mem[i] = DW'($urandom);
        build_expected(8'h42, 8'd16);
        send_packet(8'h42, 8'd16, 100, 100, cyc, bc, sv, cons, to);
        checks++; if (to) begin errors++; $display("FAIL max_timeout: no done seen"); end
        checks++; if (got_q.size() != 20) begin errors++; $display("FAIL max_count: got %0d exp 20", got_q.size()); end
        else foreach (exp_q[i]) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL max_word%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (cyc != 21) begin errors++; $display("FAIL max_latency: got %0d exp 21", cyc); end
    endtask

    task automatic test_reset_mid();
        int cyc, bc, sv, cons, pidx; bit to;
        for (int i = 0; i < 5; i++) pl_mem[i] = DW'($urandom);
        pidx = 0;
        @(negedge clk);
        start_valid = 1'b1; start_cmd = 8'h33; start_length = 8'd5;
        tx_ready = 1'b1; payload_valid = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start_valid = 1'b0;
            if (c >= 4) pidx = 1;
            payload_data = pl_mem[pidx];
        end
        @(negedge clk);
        rst_n = 1'b0; #1;
        checks++; if (tx_valid !== 1'b0 || tx_data !== '0) begin errors++; $display("FAIL rstmid_tx: got v=%b d=%h exp 0 0", tx_valid, tx_data); end
        checks++; if (busy !== 1'b0 || start_ready !== 1'b1 || payload_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ctl: got busy=%b sr=%b pr=%b exp 0 1 0", busy, start_ready, payload_ready); end
        payload_valid = 1'b0; tx_ready = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        send_packet(8'h01, 8'd0, 100, 100, cyc, bc, sv, cons, to);
        checks++; if (got_q.size() != 4) begin errors++; $display("FAIL rstmid_count: got %0d exp 4", got_q.size()); end
        else begin
            checks++; if (got_q[2] !== 32'h2E || got_q[3] !== 32'h3E) begin errors++; $display("FAIL rstmid_crc: got %h %h exp 2e 3e", got_q[2], got_q[3]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_a [$];
        logic [DW-1:0] dq [11];
        logic          vq [11];
        logic          dnq [11];
        build_expected(8'hA5, 8'd0);
        exp_a = exp_q;
        build_expected(8'h01, 8'd0);
        @(negedge clk);
        start_valid = 1'b1; start_cmd = 8'h01; start_length = 8'd0;
        tx_ready = 1'b1; payload_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) start_cmd = 8'hA5;
            if (c == 6) start_valid = 1'b0;
            #1;
            vq[c] = tx_valid; dq[c] = tx_data; dnq[c] = done;
        end
        tx_ready = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            checks++; if (vq[c] !== 1'b1 || dq[c] !== exp_q[c-1]) begin errors++; $display("FAIL b2b_a%0d: got v=%b d=%h exp 1 %h", c, vq[c], dq[c], exp_q[c-1]); end
            checks++; if (vq[c+5] !== 1'b1 || dq[c+5] !== exp_a[c-1]) begin errors++; $display("FAIL b2b_b%0d: got v=%b d=%h exp 1 %h", c, vq[c+5], dq[c+5], exp_a[c-1]); end
        end
        checks++; if (dnq[5] !== 1'b1 || vq[5] !== 1'b0) begin errors++; $display("FAIL b2b_done1: got done=%b v=%b exp 1 0", dnq[5], vq[5]); end
        checks++; if (dnq[10] !== 1'b1) begin errors++; $display("FAIL b2b_done2: got %b exp 1", dnq[10]); end
    endtask

    task automatic test_random();
        int cyc, bc, sv, cons; bit to;
        logic [7:0] cmd, len;
        for (int p = 0; p < 8; p++) begin
            cmd = 8'($urandom);
            len = 8'($urandom_range(MAXP));
            for (int i = 0; i < int'(MAXP); i++) pl_mem[i] = DW'($urandom);
            build_expected(cmd, len);
            send_packet(cmd, len, int'($urandom_range(100, 30)), int'($urandom_range(100, 30)), cyc, bc, sv, cons, to);
            checks++; if (to) begin errors++; $display("FAIL rnd%0d_timeout: no done seen", p); end
            checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd%0d_count: got %0d exp %0d", p, got_q.size(), exp_q.size()); end
            else foreach (exp_q[i]) begin
                checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_word%0d: got %h exp %h", p, i, got_q[i], exp_q[i]); end
            end
            checks++; if (sv != 0) begin errors++; $display("FAIL rnd%0d_stall: got %0d violations exp 0", p, sv); end
            checks++; if (cons != int'(len)) begin errors++; $display("FAIL rnd%0d_consumed: got %0d exp %0d", p, cons, len); end
        end
    endtask

    initial begin
        rst_n = 1'b0; start_valid = 1'b0; start_cmd = '0; start_length = '0;
        payload_data = '0; payload_valid = 1'b0; tx_ready = 1'b0;
        for (int i = 0; i < int'(MAXP); i++) pl_mem[i] = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_zero_len();
        test_basic(100, 100, "basic");
        test_basic(-1, 50, "stall");
        test_len_err();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
